// File: rtl/mantissa_compare_seq.sv
// Sequential MSB-first magnitude comparator for unpacked "1.M" mantissas.
// One D-bit chunk per cycle; stops at the first differing chunk.
module mantissa_compare_seq #(
  parameter int unsigned M = 24,
  parameter int unsigned D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] Mx,
  input  logic [M-1:0] My,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         Mx_greater_than_My,
  output logic         Mx_equal_My,
  output logic         busy
);

  localparam int unsigned N  = (M + D - 1) / D;
  localparam int unsigned P  = N * D;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state;
  logic [IW-1:0]   r_idx;
  logic [P-1:0]    r_x;
  logic [P-1:0]    r_y;
  logic            r_gt;
  logic            r_eq;

  logic [P-1:0]    w_x_pad;
  logic [P-1:0]    w_y_pad;
  logic [D-1:0]    w_x_chunk;
  logic [D-1:0]    w_y_chunk;

  // Zero padding on the LSB side keeps the MSB alignment of both operands.
  assign w_x_pad = P'(Mx) << (P - M);
  assign w_y_pad = P'(My) << (P - M);

  // Operands shift left as chunks match, so the active chunk is always on top.
  assign w_x_chunk = r_x[P-1 -: D];
  assign w_y_chunk = r_y[P-1 -: D];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_x     <= w_x_pad;
            r_y     <= w_y_pad;
            r_idx   <= IW'(N - 1);
            r_state <= StRun;
          end
        end
        StRun: begin
          if (w_x_chunk > w_y_chunk) begin
            r_gt    <= 1'b1;
            r_eq    <= 1'b0;
            r_state <= StDone;
          end else if (w_x_chunk != w_y_chunk) begin
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_state <= StDone;
          end else if (r_idx == '0) begin
            r_gt    <= 1'b0;
            r_eq    <= 1'b1;
            r_state <= StDone;
          end else begin
            r_idx <= r_idx - 1'b1;
            r_x   <= r_x << D;
            r_y   <= r_y << D;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready           = (r_state == StIdle);
  assign busy               = (r_state != StIdle);
  assign out_valid          = (r_state == StDone);
  assign Mx_greater_than_My = r_gt;
  assign Mx_equal_My        = r_eq;

endmodule

// File: tb/tb_mantissa_compare_seq.sv
// Directed bench for mantissa_compare_seq: three configurations (24/8, 23/8, 8/8)
// with a scoreboard of expected results and latencies.
module tb_mantissa_compare_seq;

  logic        clk;
  logic [2:0]  rst_n, iv, ordy, ir, ov, gt, eq, bsy;
  logic [23:0] mx [3];
  logic [23:0] my [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int   d;
    logic gt;
    logic eq;
    int   lat;
  } exp_t;

  exp_t sb[$];

  mantissa_compare_seq #(.M(24), .D(8)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .Mx(mx[0]), .My(my[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .Mx_greater_than_My(gt[0]), .Mx_equal_My(eq[0]), .busy(bsy[0])
  );

  mantissa_compare_seq #(.M(23), .D(8)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .Mx(mx[1][22:0]), .My(my[1][22:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .Mx_greater_than_My(gt[1]), .Mx_equal_My(eq[1]), .busy(bsy[1])
  );

  mantissa_compare_seq #(.M(8), .D(8)) dut_c (
    .clk(clk), .rst_n(rst_n[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .Mx(mx[2][7:0]), .My(my[2][7:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .Mx_greater_than_My(gt[2]), .Mx_equal_My(eq[2]), .busy(bsy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: compare full values, then find the first differing padded chunk.
  function automatic void model(input int d, input logic [23:0] x, input logic [23:0] y,
                                output logic egt, output logic eeq, output int lat);
    int m, n, p;
    logic [31:0] px, py;
    bit found;
    m = (d == 0) ? 24 : ((d == 1) ? 23 : 8);
    n = (m + 7) / 8;
    p = n * 8;
    px = 32'(x) & ((32'd1 << m) - 32'd1);
    py = 32'(y) & ((32'd1 << m) - 32'd1);
    egt = (px > py);
    eeq = (px == py);
    px = px << (p - m);
    py = py << (p - m);
    lat = n + 1;
    found = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!found && (((px >> (i * 8)) & 32'hFF) != ((py >> (i * 8)) & 32'hFF))) begin
        lat = (n - i) + 1;
        found = 1'b1;
      end
    end
  endfunction

  task automatic send(input int d, input logic [23:0] x, input logic [23:0] y, input bit track);
    exp_t e;
    chk("in_ready_at_offer", 32'(ir[d]), 32'd1);
    mx[d] = x;
    my[d] = y;
    iv[d] = 1'b1;
    if (track) begin
      e.d = d;
      model(d, x, y, e.gt, e.eq, e.lat);
      sb.push_back(e);
    end
    step();
    iv[d] = 1'b0;
    mx[d] = 24'($urandom);
    my[d] = 24'($urandom);
  endtask

  // Entered at c0+1; counts cycles until out_valid with a bound.
  task automatic collect(input int d, input string tag);
    exp_t e;
    int n;
    n = 1;
    while (ov[d] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_out_valid"}, 32'(ov[d]), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_latency"}, 32'(n), 32'(e.lat));
      chk({tag, "_gt"}, 32'(gt[d]), 32'(e.gt));
      chk({tag, "_eq"}, 32'(eq[d]), 32'(e.eq));
    end
  endtask

  task automatic txn(input int d, input logic [23:0] x, input logic [23:0] y, input string tag);
    send(d, x, y, 1'b1);
    collect(d, tag);
    step();
    chk({tag, "_idle_busy"}, 32'(bsy[d]), 32'd0);
    chk({tag, "_idle_in_ready"}, 32'(ir[d]), 32'd1);
  endtask

  initial begin
    logic [23:0] rx, ry;
    rst_n = 3'b000;
    iv    = 3'b000;
    ordy  = 3'b111;
    for (int i = 0; i < 3; i++) begin
      mx[i] = '0;
      my[i] = '0;
    end
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      chk("reset_out_valid", 32'(ov[i]), 32'd0);
      chk("reset_gt", 32'(gt[i]), 32'd0);
      chk("reset_eq", 32'(eq[i]), 32'd0);
      chk("reset_busy", 32'(bsy[i]), 32'd0);
      chk("reset_in_ready", 32'(ir[i]), 32'd1);
    end
    rst_n = 3'b111;
    step();

    // Decided in the top chunk: out_valid at c0+2, idle at c0+3
    txn(0, 24'hC00000, 24'h800000, "top_chunk_gt");
    // Decided in chunk 0 either way round
    txn(0, 24'h800001, 24'h800002, "low_chunk_lt");
    txn(0, 24'h800002, 24'h800001, "low_chunk_gt");
    txn(0, 24'hABCDEF, 24'hABCDEF, "equal");
    txn(0, 24'h000001, 24'h000000, "followup_gt");

    // Reset two cycles into a run discards it and clears the held result
    send(0, 24'h800001, 24'h800002, 1'b0);
    step();
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    chk("midrst_out_valid", 32'(ov[0]), 32'd0);
    chk("midrst_gt", 32'(gt[0]), 32'd0);
    chk("midrst_eq", 32'(eq[0]), 32'd0);
    chk("midrst_in_ready", 32'(ir[0]), 32'd1);
    chk("midrst_busy", 32'(bsy[0]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_result", 32'(ov[0]), 32'd0);
    end

    // Backpressure: result held, new offers ignored
    ordy[0] = 1'b0;
    send(0, 24'h123457, 24'h123456, 1'b1);
    collect(0, "stall");
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1'b1;
      mx[0] = 24'h000000;
      my[0] = 24'hFFFFFF;
      step();
      chk("stall_out_valid", 32'(ov[0]), 32'd1);
      chk("stall_gt", 32'(gt[0]), 32'd1);
      chk("stall_eq", 32'(eq[0]), 32'd0);
      chk("stall_in_ready", 32'(ir[0]), 32'd0);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    step();
    chk("stall_release_in_ready", 32'(ir[0]), 32'd1);
    chk("stall_release_busy", 32'(bsy[0]), 32'd0);
    chk("stall_release_out_valid", 32'(ov[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_offer_not_taken", 32'(bsy[0]), 32'd0);
    end
    chk("stall_result_kept_gt", 32'(gt[0]), 32'd1);

    // Random pairs, some differing only in one chunk
    for (int i = 0; i < 8; i++) begin
      rx = 24'($urandom);
      ry = rx;
      if (i % 3 != 2) ry[(i % 3) * 8 +: 8] = 8'($urandom);
      txn(0, rx, ry, "random");
    end

    // M=23: LSB padding must not disturb the result
    txn(1, 24'h400000, 24'h3FFFFF, "pad_gt");
    txn(1, 24'h7FFFFF, 24'h7FFFFF, "pad_eq");
    txn(1, 24'h000000, 24'h000001, "pad_lt");

    // D==M: always two cycles to out_valid
    txn(2, 24'h0000A5, 24'h0000A4, "single_gt");
    txn(2, 24'h00003C, 24'h00003C, "single_eq");
    txn(2, 24'h000010, 24'h0000F0, "single_lt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
